// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the dual-DAC SPI serializer.
// The frame packer is the single place that defines the 24-bit wire format.
package dac_spi_pkg;

    localparam int FRAME_W = 24;
    localparam int DATA_W  = 16;
    localparam int CHAN_W  = 3;

    // Write input register and update DAC output.
    localparam logic [2:0] CMD_DEFAULT = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        CLR
    } state_t;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic [DATA_W-1:0] data;
    } sample_t;

    function automatic logic [FRAME_W-1:0] pack_frame(input logic [2:0] cmd, input sample_t s);
        return {2'b00, cmd, s.chan, s.data};
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer for sclk: ticks on the last cycle of every CLK_DIV-cycle
// window; load restarts the window so each frame starts phase-aligned.
module spi_half_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST) && !load;

endmodule

// File: rtl/dac_spi_tx.sv
// Flow-controlled SPI serializer for the external dual DAC, with da_clr
// pulse generation. All SPI pins are registered; only s_ready is combinational.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int         CLK_DIV    = 2,
    parameter int         CS_GAP     = 4,
    parameter int         CLR_CYCLES = 16,
    parameter logic [2:0] CMD        = CMD_DEFAULT
) (
    input  logic              clk_dds,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CHAN_W-1:0] s_chan,
    input  logic [DATA_W-1:0] s_data,
    input  logic              clr_req,
    output logic              cs_n,
    output logic              sclk,
    output logic              dout,
    output logic              da_clr,
    output logic              busy,
    output logic              frame_done
);

    localparam int               DWELL_MAX = (CS_GAP > CLR_CYCLES) ? CS_GAP : CLR_CYCLES;
    localparam int               CNT_W     = $clog2(DWELL_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_CYCLES - 1);
    localparam logic [4:0]       BITS      = 5'(FRAME_W);

    state_t             state;
    logic               clr_pend;
    logic [FRAME_W-1:0] shreg;
    logic [4:0]         bit_cnt;
    logic [CNT_W-1:0]   dwell;
    logic               tick;
    logic               accept;
    sample_t            sample;
    logic [FRAME_W-1:0] frame_in;

    assign s_ready  = (state == IDLE) && !clr_pend && !clr_req && !rst;
    assign accept   = s_valid && s_ready;
    assign sample   = '{chan: s_chan, data: s_data};
    assign frame_in = pack_frame(CMD, sample);

    spi_half_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_half_tick (
        .clk (clk_dds),
        .rst (rst),
        .load(accept),
        .tick(tick)
    );

    always_ff @(posedge clk_dds) begin
        if (rst) begin
            state      <= IDLE;
            clr_pend   <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            dwell      <= '0;
            cs_n       <= 1'b1;
            sclk       <= 1'b1;
            dout       <= 1'b0;
            da_clr     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Requests outside IDLE are remembered and merged into one pulse.
            if (clr_req && state != IDLE) begin
                clr_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (clr_pend || clr_req) begin
                        state    <= CLR;
                        clr_pend <= 1'b0;
                        da_clr   <= 1'b0;
                        dwell    <= '0;
                        busy     <= 1'b1;
                    end else if (accept) begin
                        state   <= SHIFT;
                        shreg   <= frame_in;
                        bit_cnt <= '0;
                        cs_n    <= 1'b0;
                        sclk    <= 1'b1;
                        dout    <= frame_in[FRAME_W-1];
                        busy    <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (tick) begin
                        if (sclk) begin
                            // End of setup or of a high half.
                            if (bit_cnt == BITS) begin
                                state      <= GAP;
                                cs_n       <= 1'b1;
                                dout       <= 1'b0;
                                dwell      <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                sclk <= 1'b0;
                            end
                        end else begin
                            // Rising edge: the DAC has taken the bit on the falling edge.
                            sclk    <= 1'b1;
                            shreg   <= shreg << 1;
                            dout    <= shreg[FRAME_W-2];
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                GAP: begin
                    if (dwell == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        dwell <= dwell + CNT_W'(1);
                    end
                end

                CLR: begin
                    if (dwell == CLR_LAST) begin
                        state  <= GAP;
                        da_clr <= 1'b1;
                        dwell  <= '0;
                    end else begin
                        dwell <= dwell + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
